// File: rtl/axis_mem_reader.sv
// Burst reader: streams consecutive RAM words out as AXI-stream.
// A 3-entry FIFO with read credits isolates TREADY from the RAM port.
module axis_mem_reader #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    FIN
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic              inflight;
  logic              inflight_last;

  logic [DATA_W-1:0] fifo_data [3];
  logic [2:0]        fifo_last;
  logic [1:0]        wr_ptr;
  logic [1:0]        rd_ptr;
  logic [1:0]        cnt;

  logic push;
  logic pop;
  logic credit;
  logic rd_en;
  logic last_rd;
  logic accept;

  function automatic logic [1:0] ptr_inc(
    input logic [1:0] p
  );
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Credits count both queued words and the word returning from RAM.
  assign credit  = ({1'b0, cnt} + {2'b0, inflight}) < 3'd3;
  assign rd_en   = (state == READ) && (remaining != '0) && credit;
  assign last_rd = rd_en && (remaining == LEN_W'(1));
  assign accept  = cmd_valid && cmd_ready;

  assign push = inflight;
  assign pop  = m_axis_tvalid && m_axis_tready;

  assign cmd_ready     = (state == IDLE);
  assign busy          = (state != IDLE);
  assign done          = (state == FIN);
  assign mem_rd_en     = rd_en;
  assign mem_rd_addr   = addr;
  assign m_axis_tvalid = (cnt != 2'd0);
  assign m_axis_tdata  = fifo_data[rd_ptr];
  assign m_axis_tlast  = m_axis_tvalid && fifo_last[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          state_nxt = (cmd_len != '0) ? READ : FIN;
        end
      end
      READ: begin
        if (last_rd) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_axis_tlast) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr          <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= 2'd0;
      rd_ptr        <= 2'd0;
      cnt           <= 2'd0;
    end else begin
      inflight <= rd_en;
      if (accept) begin
        addr      <= cmd_addr;
        remaining <= cmd_len;
      end else if (rd_en) begin
        addr      <= addr + ADDR_W'(1);
        remaining <= remaining - LEN_W'(1);
      end
      if (rd_en) begin
        inflight_last <= last_rd;
      end
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        cnt <= cnt + 2'd1;
      end else if (pop && !push) begin
        cnt <= cnt - 2'd1;
      end
    end
  end

  // Storage holds no control state, so it is left unreset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_rd_data;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end

endmodule

// File: tb/tb_axis_mem_reader.sv
// Bench for axis_mem_reader: RAM model plus burst-level reference
// built from address/length arithmetic.
module tb_axis_mem_reader;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int LW = 16;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          m_axis_tlast;
  logic          busy;
  logic          done;

  logic [DW-1:0] ram [DEPTH];

  int tests = 0;
  int fails = 0;

  axis_mem_reader #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .LEN_W (LW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .mem_rd_data  (mem_rd_data),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 = tready high, 1 = 1,0,0 pattern, 2 = random
  task automatic run_burst(input int a, input int l, input int mode,
                           input int abort, input bit hold);
    int cyc;
    int nreads;
    int nbeats;
    int last_hs;
    int budget;
    bit stall;
    bit fin;
    logic [DW-1:0] held;
    cmd_addr  = AW'(a);
    cmd_len   = LW'(l);
    cmd_valid = 1'b1;
    chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk); #1;
    if (!hold) cmd_valid = 1'b0;
    cyc = 1; nreads = 0; nbeats = 0; last_hs = 0;
    stall = 0; fin = 0; held = '0;
    budget = 8 * l + 40;
    while (!fin && cyc <= budget) begin
      if (abort != 0 && nbeats == abort) begin
        chk("pre_rst_tvalid", m_axis_tvalid, 1);
        chk("pre_rst_rd_en", mem_rd_en, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_rd_en", mem_rd_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        m_axis_tready = 1'b0;
        return;
      end
      chk("busy", busy, 1);
      chk("cmd_ready_busy", cmd_ready, 0);
      if (cyc == 1) chk("first_rd", mem_rd_en, l != 0);
      if (cyc < 3) chk("early_tvalid", m_axis_tvalid, 0);
      if (cyc == 3 && l != 0) chk("first_tvalid", m_axis_tvalid, 1);
      if (mem_rd_en) begin
        chk("rd_addr", mem_rd_addr, (a + nreads) % DEPTH);
        nreads++;
        chk("rd_overrun", nreads <= l, 1);
      end
      chk("outstanding", (nreads - nbeats) <= 3, 1);
      if (stall) begin
        chk("stall_tvalid", m_axis_tvalid, 1);
        chk("stall_tdata", m_axis_tdata, held);
      end
      if (done) begin
        chk("done_beats", nbeats, l);
        chk("done_after_last", cyc, (l == 0) ? 1 : last_hs + 1);
        if (mode == 0) chk("done_cyc", cyc, (l == 0) ? 1 : l + 3);
        chk("done_tvalid", m_axis_tvalid, 0);
        fin = 1;
      end else begin
        case (mode)
          0: m_axis_tready = 1'b1;
          1: m_axis_tready = (cyc % 3) == 0;
          default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
        if (m_axis_tvalid) begin
          chk("tdata", m_axis_tdata, ram[(a + nbeats) % DEPTH]);
          chk("tlast", m_axis_tlast, nbeats == l - 1);
          if (m_axis_tready) begin
            nbeats++;
            last_hs = cyc;
          end
        end
        stall = m_axis_tvalid && !m_axis_tready;
        held  = m_axis_tdata;
        @(posedge clk); #1;
        cyc++;
      end
    end
    chk("no_timeout", fin, 1);
    m_axis_tready = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse", done, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    chk("busy_clear", busy, 0);
  endtask

  initial begin
    int a;
    for (int i = 0; i < DEPTH; i++) ram[i] = DW'(i * 'h11);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_tvalid", m_axis_tvalid, 0);
    chk("reset_rd_en", mem_rd_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_tlast", m_axis_tlast, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_burst('h010, 4, 0, 0, 0);

    for (int i = 0; i < DEPTH; i++) ram[i] = $urandom;
    run_burst(int'($urandom_range(0, DEPTH - 1)), 8, 1, 0, 0);
    run_burst('h3FE, 4, 0, 0, 0);
    run_burst(int'($urandom_range(0, DEPTH - 1)), 1, 0, 0, 0);
    run_burst(int'($urandom_range(0, DEPTH - 1)), 0, 0, 0, 0);

    run_burst(int'($urandom_range(0, DEPTH - 1)), 10, 0, 3, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("in_rst_done", done, 0);
    chk("in_rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_done", done, 0);
      chk("post_rst_tvalid", m_axis_tvalid, 0);
      chk("post_rst_cmd_ready", cmd_ready, 1);
    end
    run_burst(int'($urandom_range(0, DEPTH - 1)), 2, 0, 0, 0);

    a = int'($urandom_range(0, DEPTH - 1));
    run_burst(a, 3, 0, 0, 1);
    run_burst(a, 3, 0, 0, 0);

    for (int k = 0; k < 8; k++) begin
      run_burst(int'($urandom_range(0, DEPTH - 1)),
                int'($urandom_range(0, 20)), 2, 0, 0);
    end
    run_burst('h3F0, 40, 2, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
